// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// Handles decode stall, PC redirect/flush and HLT freeze.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_redirect,
  input  logic [15:0] pc_target,
  output logic        imem_rd_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_rdy,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted
);

  typedef enum logic {S_FETCH, S_HALT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic        r_buf_valid;
  logic [15:0] r_buf_instr;
  logic [15:0] r_buf_pc;
  logic [15:0] r_ifid_instr;
  logic [15:0] r_ifid_pc;
  logic        r_ifid_valid;

  logic        w_accept;
  logic        w_drain;
  logic        w_direct;
  logic        w_hlt_write;
  logic [15:0] w_pc_inc;

  assign w_pc_inc = r_pc + 16'd1;
  assign w_accept = imem_rd_en & imem_rdy;
  assign w_drain  = !stall && r_buf_valid;
  assign w_direct = !stall && !r_buf_valid && w_accept;

  // HLT takes effect only when the word actually lands in IF/ID, not when it is buffered
  assign w_hlt_write = !pc_redirect &&
                       ((w_drain  && (r_buf_instr[15:12] == HALT_OPCODE)) ||
                        (w_direct && (imem_rdata[15:12]  == HALT_OPCODE)));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (pc_redirect)
      w_state_nxt = S_FETCH;
    else if ((r_state == S_FETCH) && w_hlt_write)
      w_state_nxt = S_HALT;
  end

  always_comb begin
    imem_rd_en = (r_state == S_FETCH) && !r_buf_valid && !rst;
    halted     = (r_state == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_buf_valid  <= 1'b0;
      r_buf_instr  <= NOP_INSTR;
      r_buf_pc     <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else if (pc_redirect) begin
      r_pc         <= pc_target;
      r_buf_valid  <= 1'b0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else if (!stall) begin
      if (r_buf_valid) begin
        r_ifid_instr <= r_buf_instr;
        r_ifid_pc    <= r_buf_pc;
        r_ifid_valid <= 1'b1;
        r_buf_valid  <= 1'b0;
      end else if (w_accept) begin
        r_ifid_instr <= imem_rdata;
        r_ifid_pc    <= w_pc_inc;
        r_ifid_valid <= 1'b1;
        r_pc         <= w_pc_inc;
      end else begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_pc    <= r_pc;
        r_ifid_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_buf_instr <= imem_rdata;
      r_buf_pc    <= w_pc_inc;
      r_buf_valid <= 1'b1;
      r_pc        <= w_pc_inc;
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_instr = r_ifid_instr;
  assign if_id_pc    = r_ifid_pc;
  assign if_id_valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected IF/ID words queued as beats are driven,
// popped whenever decode would consume a new valid word.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        pc_redirect;
  logic [15:0] pc_target;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_rdy;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;

  logic [15:0] mem [65536];
  logic [31:0] sb [$];
  logic [15:0] exp_pc;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  fetch_unit #(
    .RESET_PC   (16'h0000),
    .NOP_INSTR  (16'h0000),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .pc_redirect(pc_redirect),
    .pc_target  (pc_target),
    .imem_rd_en (imem_rd_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_rdy   (imem_rdy),
    .if_id_instr(if_id_instr),
    .if_id_pc   (if_id_pc),
    .if_id_valid(if_id_valid),
    .halted     (halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A new valid IF/ID word is consumed only when decode was not stalled in the cycle that produced it.
  task automatic tick();
    logic        sp;
    logic [31:0] e;
    sp = stall;
    @(posedge clk);
    #1;
    if (if_id_valid && !sp) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_word: observed %h expected none", if_id_instr);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_instr", if_id_instr, e[31:16]);
        chk("sb_pc", if_id_pc, e[15:0]);
      end
    end
  endtask

  task automatic beat();
    sb.push_back({mem[exp_pc], exp_pc + 16'd1});
    exp_pc = exp_pc + 16'd1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 | 16'(i & 32'hFFF);
    mem[16'h0000] = 16'h1123;
    mem[16'h0001] = 16'h2456;
    mem[16'h0005] = 16'h3AB0;
    mem[16'h0041] = 16'hF000;

    rst = 1'b1; stall = 1'b0; pc_redirect = 1'b0; pc_target = '0; imem_rdy = 1'b0;
    exp_pc = 16'h0000;
    tick();
    chk("rst_instr", if_id_instr, 16'h0000);
    chk("rst_pc", if_id_pc, 16'h0000);
    chk("rst_valid", 16'(if_id_valid), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_rd_en", 16'(imem_rd_en), 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);

    // 1: back-to-back fetch
    rst = 1'b0; imem_rdy = 1'b1; #1;
    chk("t1_rd_en", 16'(imem_rd_en), 16'd1);
    beat();
    chk("t1_first_instr", if_id_instr, 16'h1123);
    chk("t1_first_pc", if_id_pc, 16'h0001);
    beat();
    chk("t1_second_instr", if_id_instr, 16'h2456);
    beat();
    beat();
    chk("t1_addr", imem_addr, 16'h0004);

    // 2: wait states
    imem_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_addr_hold", imem_addr, 16'h0004);
      chk("t2_bubble", 16'(if_id_valid), 16'd0);
    end
    imem_rdy = 1'b1;
    beat();
    chk("t2_pc", if_id_pc, 16'h0005);

    // 3: stall with skid capture
    stall = 1'b1;
    sb.push_back({16'h3AB0, 16'h0006});
    exp_pc = 16'h0006;
    tick();
    chk("t3_hold_instr", if_id_instr, mem[16'h0004]);
    chk("t3_hold_pc", if_id_pc, 16'h0005);
    chk("t3_rd_en_off", 16'(imem_rd_en), 16'd0);
    chk("t3_addr", imem_addr, 16'h0006);
    tick();
    chk("t3_hold2_valid", 16'(if_id_valid), 16'd1);
    chk("t3_hold2_instr", if_id_instr, mem[16'h0004]);
    stall = 1'b0;
    tick();
    chk("t3_drain_instr", if_id_instr, 16'h3AB0);
    chk("t3_resume_rd_en", 16'(imem_rd_en), 16'd1);
    beat();
    chk("t3_resume_pc", if_id_pc, 16'h0007);

    // 4: redirect with buffer full and stall
    stall = 1'b1;
    tick();
    exp_pc = exp_pc + 16'd1;
    chk("t4_buf_full", 16'(imem_rd_en), 16'd0);
    pc_redirect = 1'b1; pc_target = 16'h0040;
    tick();
    pc_redirect = 1'b0; #1;
    chk("t4_addr", imem_addr, 16'h0040);
    chk("t4_valid", 16'(if_id_valid), 16'd0);
    chk("t4_instr", if_id_instr, 16'h0000);
    chk("t4_buf_empty", 16'(imem_rd_en), 16'd1);
    exp_pc = 16'h0040;
    stall = 1'b0;
    beat();

    // 5: HLT freeze and redirect out
    beat();
    chk("t5_hlt_instr", if_id_instr, 16'hF000);
    chk("t5_halted", 16'(halted), 16'd1);
    chk("t5_rd_en", 16'(imem_rd_en), 16'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t5_pc_frozen", imem_addr, 16'h0042);
      chk("t5_still_halted", 16'(halted), 16'd1);
      chk("t5_no_fetch", 16'(imem_rd_en), 16'd0);
    end
    pc_redirect = 1'b1; pc_target = 16'h0010;
    tick();
    pc_redirect = 1'b0; #1;
    chk("t5_unhalted", 16'(halted), 16'd0);
    chk("t5_redir_addr", imem_addr, 16'h0010);
    exp_pc = 16'h0010;
    beat();
    chk("t5_redir_pc", if_id_pc, 16'h0011);

    // 6: PC wrap, then reset mid-stall
    pc_redirect = 1'b1; pc_target = 16'hFFFF;
    tick();
    pc_redirect = 1'b0;
    exp_pc = 16'hFFFF;
    beat();
    chk("t6_wrap_pc", if_id_pc, 16'h0000);
    chk("t6_wrap_addr", imem_addr, 16'h0000);
    stall = 1'b1;
    tick();
    chk("t6_buffered", 16'(imem_rd_en), 16'd0);
    rst = 1'b1;
    tick();
    chk("t6_rst_instr", if_id_instr, 16'h0000);
    chk("t6_rst_pc", if_id_pc, 16'h0000);
    chk("t6_rst_valid", 16'(if_id_valid), 16'd0);
    chk("t6_rst_halted", 16'(halted), 16'd0);
    chk("t6_rst_addr", imem_addr, 16'h0000);
    chk("t6_rst_rd_en", 16'(imem_rd_en), 16'd0);
    rst = 1'b0; stall = 1'b0; #1;
    chk("t6_buf_cleared", 16'(imem_rd_en), 16'd1);
    exp_pc = 16'h0000;
    beat();
    chk("t6_refetch", if_id_instr, 16'h1123);

    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
